// File: rtl/sr_latch_sequencer_pkg.sv
// Shared types and helpers for the SR latch sequencer.
// Holds the sequencer state enum, the op encodings and a constant clog2.
package sr_seq_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        DRIVE = 2'd2,
        GAP   = 2'd3
    } seq_state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    // Width needed to index 'value' distinct items; 1 and below give 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sr_latch_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// 'ptr', wrapping from NREQ-1 to 0. The pointer register lives in the caller.
module rr_arbiter
    import sr_seq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [clog2(NREQ)-1:0]   ptr,
    output logic [NREQ-1:0]          grant,
    output logic                     grant_valid
);

    localparam int PTR_W = clog2(NREQ);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign grant_valid = found;

endmodule

// File: rtl/sr_latch_sequencer.sv
// Shares one SR latch between NREQ requesters: round-robin grant, timed s/r pulse,
// then a recovery gap. Optional q feedback check enabled by SR_FEEDBACK_CHECK_EN.
module sr_latch_sequencer
    import sr_seq_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_op,
    output logic [NREQ-1:0] req_ready,
    output logic            s,
    output logic            r,
    output logic            q_cmd,
    output logic            busy,
    input  logic            q_fb,
    output logic            err
);

    localparam int PTR_W = clog2(NREQ);
    localparam int CNT_W = clog2(((PULSE_W > GAP_W) ? PULSE_W : GAP_W) + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
    localparam logic [PTR_W-1:0] LAST_REQ   = PTR_W'(NREQ - 1);

    seq_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0]  grant;
    logic             grant_valid;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] next_ptr;
    logic             winner_op;
    logic             accept;
    logic             gap_last;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    always_comb begin
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                winner = PTR_W'(i);
            end
        end
    end

    assign next_ptr  = (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);
    assign winner_op = |(grant & req_op);

    // Handshake is only offered from a settled IDLE and never while reset is held.
    assign accept    = (state == IDLE) && !rst && grant_valid;
    assign req_ready = accept ? grant : '0;
    assign busy      = (state != IDLE);
    assign gap_last  = (state == GAP) && (cnt == GAP_LAST);

    // s and r only ever load from op and its complement, or both zero, so s&r is impossible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            s      <= 1'b0;
            r      <= 1'b0;
            q_cmd  <= 1'b0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                INIT: begin
                    s     <= OP_RESET;
                    r     <= ~OP_RESET;
                    q_cmd <= OP_RESET;
                    cnt   <= '0;
                    state <= DRIVE;
                end
                IDLE: begin
                    s <= 1'b0;
                    r <= 1'b0;
                    if (accept) begin
                        s      <= winner_op;
                        r      <= ~winner_op;
                        q_cmd  <= winner_op;
                        rr_ptr <= next_ptr;
                        cnt    <= '0;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == PULSE_LAST) begin
                        s     <= 1'b0;
                        r     <= 1'b0;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    s     <= 1'b0;
                    r     <= 1'b0;
                    state <= INIT;
                end
            endcase
        end
    end

`ifdef SR_FEEDBACK_CHECK_EN
    // The latch has had the whole gap to settle, so q_fb should now match the command.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (gap_last && (q_fb != q_cmd)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_q_fb;
    logic unused_gap_last;
    assign unused_q_fb     = q_fb;
    assign unused_gap_last = gap_last;
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Self-checking bench for sr_latch_sequencer: directed vector table, hand-written
// corner sequences, then random traffic against a cycle-age reference model.
module tb_sr_latch_sequencer;

    localparam int NREQ     = 4;
    localparam int PULSE_W  = 2;
    localparam int GAP_W    = 1;
    localparam int BUSY_LEN = PULSE_W + GAP_W;

`ifdef SR_FEEDBACK_CHECK_EN
    localparam logic FB_EN = 1'b1;
`else
    localparam logic FB_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_op = '0;
    logic [NREQ-1:0] req_ready;
    logic            s;
    logic            r;
    logic            q_cmd;
    logic            busy;
    logic            q_fb = 1'b0;
    logic            err;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    sr_latch_sequencer #(
        .NREQ   (NREQ),
        .PULSE_W(PULSE_W),
        .GAP_W  (GAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_op   (req_op),
        .req_ready(req_ready),
        .s        (s),
        .r        (r),
        .q_cmd    (q_cmd),
        .busy     (busy),
        .q_fb     (q_fb),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference model: time since the last grant decides everything.
    // Ages 1..PULSE_W are pulse cycles, up to BUSY_LEN are gap cycles, beyond is idle.
    int              m_age  = BUSY_LEN + 1;
    logic            m_init = 1'b1;
    int              m_ptr  = 0;
    logic            m_op   = 1'b0;
    logic            m_q    = 1'b0;
    logic            m_err  = 1'b0;
    logic [NREQ-1:0] m_g;

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] g;
        int i;
        g = '0;
        if (rst || m_init || m_age <= BUSY_LEN) return g;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic model_pulse();
        return (m_age >= 1) && (m_age <= PULSE_W);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1'b1;
            m_age  = BUSY_LEN + 1;
            m_ptr  = 0;
            m_q    = 1'b0;
            m_op   = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (FB_EN && !m_init && m_age == BUSY_LEN && q_fb !== m_q) m_err = 1'b1;
            m_g = model_ready();
            if (m_init) begin
                m_init = 1'b0;
                m_age  = 1;
                m_op   = 1'b0;
                m_q    = 1'b0;
            end else if (m_g != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (m_g[i]) begin
                        m_op  = req_op[i];
                        m_ptr = (i + 1) % NREQ;
                    end
                end
                m_q   = m_op;
                m_age = 1;
            end else if (m_age <= BUSY_LEN) begin
                m_age++;
            end
        end
    end

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [NREQ-1:0] actual,
                             input logic [NREQ-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic rst_v, input logic [NREQ-1:0] valid_v,
                                  input logic [NREQ-1:0] op_v);
        rst       = rst_v;
        req_valid = valid_v;
        req_op    = op_v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle R+4, the first IDLE cycle.
    task automatic do_reset();
        apply_stimulus(1'b1, '0, '0);
        step();
        step();
        apply_stimulus(1'b0, '0, '0);
        repeat (4) step();
    endtask

    // Invariants hold in every phase, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check_bit("s_and_r_never", s & r, 1'b0);
            check_bit("ready_onehot0", $onehot0(req_ready), 1'b1);
        end
    end

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] op;
        logic [NREQ-1:0] ready;
        logic            s;
        logic            r;
        logic            q;
        logic            busy;
        logic            err;
    } vec_t;

    vec_t vecs[14];

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [NREQ-1:0] ops;
        logic [NREQ-1:0] granted;
        logic [NREQ-1:0] exp_rdy;
        int g;

        // ready is sampled before the edge; s/r/q/busy/err after it. q_fb held 0.
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, FB_EN};
        vecs[10] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, FB_EN};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, FB_EN};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, FB_EN};
        vecs[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, FB_EN};

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].valid, vecs[i].op);
            #1;
            check_vec("tbl_ready", req_ready, vecs[i].ready);
            step();
            if (i == 0) mon_en = 1'b1;
            check_bit("tbl_s", s, vecs[i].s);
            check_bit("tbl_r", r, vecs[i].r);
            check_bit("tbl_q_cmd", q_cmd, vecs[i].q);
            check_bit("tbl_busy", busy, vecs[i].busy);
            check_bit("tbl_err", err, vecs[i].err);
        end

        $display("[TB] all requesters valid, alternating ops");
        do_reset();
        ops = 4'b1010;
        apply_stimulus(1'b0, 4'b1111, ops);
        for (int c = 0; c <= 16; c++) begin
            #1;
            exp_rdy = '0;
            if (c % 4 == 0) exp_rdy[(c / 4) % 4] = 1'b1;
            check_vec("rr_ready", req_ready, exp_rdy);
            step();
            if (c % 4 <= 1) begin
                g = (c / 4) % 4;
                check_bit("rr_s", s, ops[g]);
                check_bit("rr_r", r, ~ops[g]);
            end
        end

        $display("[TB] late request overtakes by round robin");
        do_reset();
        apply_stimulus(1'b0, 4'b0100, 4'b0100);
        #1;
        check_vec("late_first", req_ready, 4'b0100);
        step();
        apply_stimulus(1'b0, 4'b0110, 4'b0100);
        step();
        step();
        step();
        #1;
        check_vec("late_second", req_ready, 4'b0010);
        step();
        check_bit("late_second_r", r, 1'b1);
        check_bit("late_second_s", s, 1'b0);
        repeat (3) step();
        #1;
        check_vec("late_third", req_ready, 4'b0100);
        step();
        check_bit("late_third_s", s, 1'b1);

        $display("[TB] reset during DRIVE");
        do_reset();
        apply_stimulus(1'b0, 4'b0001, 4'b0001);
        #1;
        check_vec("mid_grant", req_ready, 4'b0001);
        step();
        check_bit("mid_s1", s, 1'b1);
        apply_stimulus(1'b0, 4'b0000, 4'b0000);
        step();
        check_bit("mid_s2", s, 1'b1);
        apply_stimulus(1'b1, 4'b0001, 4'b0001);
        #1;
        check_vec("mid_rst_ready", req_ready, 4'b0000);
        step();
        check_bit("mid_rst_s", s, 1'b0);
        check_bit("mid_rst_r", r, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b1);
        check_bit("mid_rst_q", q_cmd, 1'b0);
        apply_stimulus(1'b0, 4'b0001, 4'b0001);
        #1;
        check_vec("mid_init_ready", req_ready, 4'b0000);
        step();
        check_bit("mid_reinit_r1", r, 1'b1);
        check_bit("mid_reinit_s1", s, 1'b0);
        step();
        check_bit("mid_reinit_r2", r, 1'b1);
        step();
        check_bit("mid_reinit_r3", r, 1'b0);
        check_bit("mid_reinit_busy3", busy, 1'b1);
        step();
        check_bit("mid_reinit_busy4", busy, 1'b0);

        $display("[TB] randomized traffic against reference model");
        apply_stimulus(1'b1, '0, '0);
        step();
        step();
        granted = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_bit("rnd_s", s, model_pulse() && m_op);
            check_bit("rnd_r", r, model_pulse() && !m_op);
            check_bit("rnd_q_cmd", q_cmd, m_q);
            check_bit("rnd_busy", busy, m_init || (m_age <= BUSY_LEN));
            check_bit("rnd_err", err, m_err);
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (granted[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_op[i]    = ($urandom_range(0, 1) == 1);
                end
            end
            q_fb = ($urandom_range(0, 15) == 0) ? ($urandom_range(0, 1) == 1) : m_q;
            #1;
            granted = model_ready();
            check_vec("rnd_ready", req_ready, granted);
            step();
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_latch_sequencer.md
Name: sr_latch_sequencer

Overview:
Clocked controller that shares one SR latch between NREQ requesters. Each requester asks to set or reset the latch through a valid/ready handshake. A round-robin arbiter picks one request at a time. The sequencer then drives s/r as timed pulses with guaranteed recovery gaps, so the latch is never driven with s=r=1. It sits between synchronous control logic and the asynchronous latch datapath.

Parameters:
NREQ, 4, number of requesters; legal range 2..16
PULSE_W, 2, cycles s or r is held high per operation; must be >=1
GAP_W, 1, cycles s=r=0 after each pulse before the next grant; must be >=1

Ports:
clk  input  1  single clock; all logic updates on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_op  input  NREQ  per-requester op: 1=set, 0=reset; must be stable while valid
req_ready  output  NREQ  one-hot accept; a transfer occurs when valid&ready
s  output  1  latch set drive, registered
r  output  1  latch reset drive, registered
q_cmd  output  1  shadow of the last commanded latch value, registered
busy  output  1  high in INIT, DRIVE and GAP
q_fb  input  1  latch q feedback; used only with the optional feature
err  output  1  sticky feedback mismatch flag

Behaviour:
- Clock/reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=INIT, s=0, r=0, q_cmd=0, err=0, rr pointer=0, pulse/gap counter=0. While rst is high, req_ready=0.
- States: INIT, IDLE, DRIVE, GAP.
- INIT: in the first cycle with rst low (cycle R), load op=0 and go to DRIVE. r=1 for cycles R+1..R+PULSE_W. This forces the latch to a known 0. req_valid is ignored and req_ready=0.
- IDLE: req_ready is combinational. It selects the first asserted req_valid at or after the rr pointer, wrapping NREQ-1 -> 0.
  - In accept cycle T: capture op, set pointer=(winner+1) mod NREQ, go to DRIVE.
  - At the next edge, load s=op, r=~op, q_cmd=op.
  - With no valid request, stay in IDLE with s=r=0.
- DRIVE: hold s/r for exactly PULSE_W cycles (T+1..T+PULSE_W). On the last cycle, load s=r=0 and go to GAP.
- GAP: s=r=0 for GAP_W cycles (T+PULSE_W+1..T+PULSE_W+GAP_W), then go to IDLE.
  - The earliest next accept is T+PULSE_W+GAP_W+1, giving one grant per PULSE_W+GAP_W+1 cycles.
- req_ready is 0 in every state except IDLE.
- Requesters must hold valid and op until ready. Dropping valid before a grant is legal and simply withdraws the request.
- Invariants:
  - s&r is never 1.
  - s|r is never high in consecutive operations without at least GAP_W zero cycles between them.
  - At most one req_ready bit is high.
- A request matching the current q_cmd is still pulsed; there is no skip optimisation.
- rst asserted mid-operation (any state): at the next edge s=r=0, state=INIT, pointer=0, err=0. After rst deasserts, the INIT reset pulse is reissued.
- Counter width is clog2(max(PULSE_W,GAP_W)+1).

Optional Feature:
SR_FEEDBACK_CHECK_EN
- Defined: on the last GAP cycle, compare q_fb to q_cmd. A mismatch sets err=1 at the next edge; err stays set until rst. INIT is also checked, against 0.
- Undefined: q_fb is ignored and err is tied to 0. Ports exist in both builds.

Decomposition:
- Package sr_seq_pkg holds:
  - the state enum (INIT, IDLE, DRIVE, GAP);
  - constants OP_SET=1'b1 and OP_RESET=1'b0;
  - a clog2 helper function.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector and pointer; outputs one-hot grant and a valid flag. It is purely combinational. The pointer register stays in sr_latch_sequencer.

Test Plan:
- Defaults; release rst at cycle R with no requests -> r=1 at R+1..R+2, s=0, busy=1 through R+3, first possible req_ready at R+4, q_cmd=0.
- req_valid[0]=1, req_op[0]=1, accepted at T -> req_ready=4'b0001 at T only; s=1 at T+1..T+2; s=0 at T+3; q_cmd=1 from T+1; next grant no earlier than T+4.
- All four valid continuously with alternating ops, pointer=0 -> grants 0,1,2,3,0 at T, T+4, T+8, T+12, T+16; s&r never 1 (assertion).
- req 2 valid alone, then req 1 raised while req 2 pending in DRIVE -> after GAP, req 1 is granted next; pointer advances to 2.
- rst high during the second DRIVE cycle -> next edge s=r=0, req_ready=0, state INIT; after release the r pulse repeats at R+1..R+2.
- SR_FEEDBACK_CHECK_EN defined: set accepted at T, q_fb held 0 -> err=1 from T+4 and stays 1 until rst. Same stimulus without the macro -> err=0 throughout.
